// File: rtl/mc_cu.sv
// mc_cu: multicycle control unit for a shared-memory-port MIPS subset CPU.
// Walks the datapath through IF, ID, EXE, MEM and WB. Fetch and data accesses
// wait on a ready handshake that has a bounded wait.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an undefined
// instruction parks the unit in TRAP until reset. When it is not defined,
// an undefined instruction behaves as a nop.
//
// Memory handshake: mem_req is high for every cycle spent in IF or MEM. An
// access completes in the cycle where mem_req and mem_ready are both high.
// In that cycle the completing strobes (wir/wpc, or wmem) take effect and the
// state advances. mem_ready has no effect in any other state.
module mc_cu #(
    parameter int MEM_WAIT_LIMIT = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       wir,
    output logic       wpc,
    output logic       wreg,
    output logic       regrt,
    output logic       jal,
    output logic       m2reg,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       mem_timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Counter value at which a still-waiting access gives up.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MEM_WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_r, r_legal, r_shift, r_jr;
    logic [3:0] r_aluc;
    logic       i_alu, i_lw, i_sw, i_lui;
    logic       legal;
    logic       wait_state, timeout_hit;

    // Instruction decode: R-type function class and ALU code, plus legality.
    always_comb begin
        is_r    = (op == OP_RTYPE);
        r_legal = 1'b1;
        r_shift = 1'b0;
        r_jr    = 1'b0;
        r_aluc  = ALU_ADD;
        unique case (func)
            F_ADD:   r_aluc = ALU_ADD;
            F_SUB:   r_aluc = ALU_SUB;
            F_AND:   r_aluc = ALU_AND;
            F_OR:    r_aluc = ALU_OR;
            F_XOR:   r_aluc = ALU_XOR;
            F_SLL:   begin r_aluc = ALU_SLL; r_shift = 1'b1; end
            F_SRL:   begin r_aluc = ALU_SRL; r_shift = 1'b1; end
            F_SRA:   begin r_aluc = ALU_SRA; r_shift = 1'b1; end
            F_JR:    r_jr = 1'b1;
            default: r_legal = 1'b0;
        endcase
        i_alu = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        i_lui = (op == OP_LUI);
        i_lw  = (op == OP_LW);
        i_sw  = (op == OP_SW);
        legal = (is_r && r_legal) || i_alu || i_lui || i_lw || i_sw ||
                (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL);
    end

    assign wait_state  = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout_hit = (MEM_WAIT_LIMIT > 0) && wait_state && !mem_ready && (cnt_q == LIMIT_M1);

    // State and wait-counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait counter: counts unanswered cycles in IF/MEM and restarts on every transition or abort.
    always_comb begin
        if ((state_d != state_q) || timeout_hit) begin
            cnt_d = '0;
        end else if (wait_state && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next-state and datapath control for the current state.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        iord        = 1'b0;
        wmem        = 1'b0;
        wir         = 1'b0;
        wpc         = 1'b0;
        wreg        = 1'b0;
        regrt       = 1'b0;
        jal         = 1'b0;
        m2reg       = 1'b0;
        shift       = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        sext        = 1'b0;
        aluc        = ALU_ADD;
        pcsource    = 2'b00;
        mem_timeout = 1'b0;

        unique case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (timeout_hit) begin
                    // The PC is left alone, so the same address is fetched again.
                    mem_timeout = 1'b1;
                end else if (mem_ready) begin
                    wir     = 1'b1;
                    wpc     = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // The ALU computes PC+(imm<<2) so that ALUout holds the branch target for EXE.
                alusrcb = 2'b11;
                if (op == OP_J) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    state_d  = S_IF;
                end else if (op == OP_JAL) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                    state_d  = S_IF;
                end else if (is_r && r_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                    state_d  = S_IF;
                end else if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_IF;
`endif
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                state_d = S_IF;
                if (is_r) begin
                    alusrcb = 2'b00;
                    shift   = r_shift;
                    aluc    = r_aluc;
                    state_d = S_WB;
                end else begin
                    unique case (op)
                        OP_ADDI: begin alusrcb = 2'b10; sext = 1'b1; aluc = ALU_ADD; state_d = S_WB; end
                        OP_ANDI: begin alusrcb = 2'b10; aluc = ALU_AND; state_d = S_WB; end
                        OP_ORI:  begin alusrcb = 2'b10; aluc = ALU_OR;  state_d = S_WB; end
                        OP_XORI: begin alusrcb = 2'b10; aluc = ALU_XOR; state_d = S_WB; end
                        OP_LUI:  begin alusrcb = 2'b10; aluc = ALU_LUI; state_d = S_WB; end
                        OP_LW, OP_SW: begin
                            alusrcb = 2'b10;
                            sext    = 1'b1;
                            aluc    = ALU_ADD;
                            state_d = S_MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            alusrcb = 2'b00;
                            sext    = 1'b1;
                            aluc    = ALU_SUB;
                            if ((op == OP_BEQ) ? z : !z) begin
                                wpc      = 1'b1;
                                pcsource = 2'b01;
                            end
                        end
                        default: state_d = S_IF;
                    endcase
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (timeout_hit) begin
                    // The aborted access is dropped and the whole instruction is refetched.
                    mem_timeout = 1'b1;
                    state_d     = S_IF;
                end else begin
                    wmem = i_sw;
                    if (mem_ready) begin
                        state_d = i_lw ? S_WB : S_IF;
                    end
                end
            end
            S_WB: begin
                wreg    = 1'b1;
                regrt   = i_alu || i_lui || i_lw;
                m2reg   = i_lw;
                state_d = S_IF;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_IF;
`endif
            end
            default: state_d = S_IF;
        endcase

        // While reset is asserted, no strobe or select may leak out.
        if (reset) begin
            mem_req     = 1'b0;
            iord        = 1'b0;
            wmem        = 1'b0;
            wir         = 1'b0;
            wpc         = 1'b0;
            wreg        = 1'b0;
            regrt       = 1'b0;
            jal         = 1'b0;
            m2reg       = 1'b0;
            shift       = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            sext        = 1'b0;
            aluc        = 4'b0000;
            pcsource    = 2'b00;
            mem_timeout = 1'b0;
        end
    end

    assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed and randomized checks of mc_cu against an
// instruction-level reference model. The model is table-driven: it knows
// each instruction's class, ALU code and extension, and it expands each
// instruction into its expected per-cycle control vectors.
// Optional macro: ILLEGAL_TRAP_EN selects the trap expectations.
module tb_mc_cu;

  localparam int TB_LIMIT = 4;

  logic       clock, reset;
  logic [5:0] op, func;
  logic       z, mem_ready;
  logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, jal, m2reg, shift, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic       sext, mem_timeout;
  logic [3:0] aluc;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, jal, m2reg, shift, alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       mem_timeout;
  } ctl_t;

  ctl_t obs;
  assign obs = {state, mem_req, iord, wmem, wir, wpc, wreg, regrt, jal, m2reg, shift,
                alusrca, alusrcb, sext, aluc, pcsource, mem_timeout};

  mc_cu #(.MEM_WAIT_LIMIT(TB_LIMIT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc), .wreg(wreg),
    .regrt(regrt), .jal(jal), .m2reg(m2reg), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .sext(sext), .aluc(aluc), .pcsource(pcsource),
    .mem_timeout(mem_timeout), .state(state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // instruction table: classes and ALU behaviour taken from the instruction set
  localparam int C_R = 0, C_SH = 1, C_JR = 2, C_IALU = 3, C_LUI = 4, C_LW = 5;
  localparam int C_SW = 6, C_BEQ = 7, C_BNE = 8, C_J = 9, C_JAL = 10;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    int         cls;
    logic [3:0] aluc;
    logic       sext;
  } ins_t;

  ins_t tbl [20] = '{
    '{6'b000000, 6'b100000, C_R,    4'b0000, 1'b0},  // add
    '{6'b000000, 6'b100010, C_R,    4'b0100, 1'b0},  // sub
    '{6'b000000, 6'b100100, C_R,    4'b0001, 1'b0},  // and
    '{6'b000000, 6'b100101, C_R,    4'b0101, 1'b0},  // or
    '{6'b000000, 6'b100110, C_R,    4'b0010, 1'b0},  // xor
    '{6'b000000, 6'b000000, C_SH,   4'b0011, 1'b0},  // sll
    '{6'b000000, 6'b000010, C_SH,   4'b0111, 1'b0},  // srl
    '{6'b000000, 6'b000011, C_SH,   4'b1111, 1'b0},  // sra
    '{6'b000000, 6'b001000, C_JR,   4'b0000, 1'b0},  // jr
    '{6'b001000, 6'b000000, C_IALU, 4'b0000, 1'b1},  // addi
    '{6'b001100, 6'b000000, C_IALU, 4'b0001, 1'b0},  // andi
    '{6'b001101, 6'b000000, C_IALU, 4'b0101, 1'b0},  // ori
    '{6'b001110, 6'b000000, C_IALU, 4'b0010, 1'b0},  // xori
    '{6'b100011, 6'b000000, C_LW,   4'b0000, 1'b1},  // lw
    '{6'b101011, 6'b000000, C_SW,   4'b0000, 1'b1},  // sw
    '{6'b000100, 6'b000000, C_BEQ,  4'b0100, 1'b1},  // beq
    '{6'b000101, 6'b000000, C_BNE,  4'b0100, 1'b1},  // bne
    '{6'b001111, 6'b000000, C_LUI,  4'b0110, 1'b0},  // lui
    '{6'b000010, 6'b000000, C_J,    4'b0000, 1'b0},  // j
    '{6'b000011, 6'b000000, C_JAL,  4'b0000, 1'b0}   // jal
  };

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [5:0] nx_op, nx_func;

  // Returns the table index of op/func, or -1 for an undefined instruction.
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    int r;
    r = -1;
    for (int k = 0; k < 20; k++)
      if (tbl[k].op == o && (o != 6'd0 || tbl[k].func == f)) r = k;
    return r;
  endfunction

  // reference model: expected control vector per phase
  function automatic ctl_t e_fetch(input logic rdy, input logic tmo);
    ctl_t e;
    e = '0;
    e.mem_req = 1'b1;
    e.alusrcb = 2'b01;
    e.mem_timeout = tmo;
    e.wir = rdy && !tmo;
    e.wpc = rdy && !tmo;
    return e;
  endfunction

  function automatic ctl_t e_decode(input int idx);
    ctl_t e;
    e = '0;
    e.st = 3'd1;
    e.alusrcb = 2'b11;
    if (idx >= 0) begin
      if (tbl[idx].cls == C_J || tbl[idx].cls == C_JAL) begin
        e.wpc = 1'b1;
        e.pcsource = 2'b11;
      end
      if (tbl[idx].cls == C_JAL) begin
        e.wreg = 1'b1;
        e.jal = 1'b1;
      end
      if (tbl[idx].cls == C_JR) begin
        e.wpc = 1'b1;
        e.pcsource = 2'b10;
      end
    end
    return e;
  endfunction

  function automatic ctl_t e_exec(input int idx, input logic zz);
    ctl_t e;
    int   c;
    c = tbl[idx].cls;
    e = '0;
    e.st = 3'd2;
    e.alusrca = 1'b1;
    e.aluc = tbl[idx].aluc;
    e.sext = tbl[idx].sext;
    e.shift = (c == C_SH);
    e.alusrcb = (c == C_R || c == C_SH || c == C_BEQ || c == C_BNE) ? 2'b00 : 2'b10;
    if ((c == C_BEQ && zz) || (c == C_BNE && !zz)) begin
      e.wpc = 1'b1;
      e.pcsource = 2'b01;
    end
    return e;
  endfunction

  function automatic ctl_t e_mem(input int idx, input logic tmo);
    ctl_t e;
    e = '0;
    e.st = 3'd3;
    e.mem_req = 1'b1;
    e.iord = 1'b1;
    e.wmem = (tbl[idx].cls == C_SW) && !tmo;
    e.mem_timeout = tmo;
    return e;
  endfunction

  function automatic ctl_t e_wb(input int idx);
    ctl_t e;
    int   c;
    c = tbl[idx].cls;
    e = '0;
    e.st = 3'd4;
    e.wreg = 1'b1;
    e.regrt = (c == C_IALU || c == C_LUI || c == C_LW);
    e.m2reg = (c == C_LW);
    return e;
  endfunction

  // scoreboard comparison
  task automatic check(input ctl_t exp, input string tag);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (op=%b func=%b)", tag, obs, exp, op, func);
  endtask

  // driver: one cycle with inputs applied at the falling edge
  task automatic step(input ctl_t exp, input logic rdy, input logic zz, input logic ld, input string tag);
    @(negedge clock);
    if (ld) begin
      op = nx_op;
      func = nx_func;
    end
    mem_ready = rdy;
    z = zz;
    #1;
    check(exp, tag);
  endtask

  // A memory phase that answers after 'delay' idle cycles, or aborts after TB_LIMIT cycles.
  task automatic wait_phase(input logic is_if, input int idx, input int delay, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic rdy, tmo;
      rdy = (i >= delay);
      tmo = !rdy && (i == TB_LIMIT - 1);
      step(is_if ? e_fetch(rdy, tmo) : e_mem(idx, tmo), rdy, 1'($urandom),
           is_if && (i == 0), is_if ? "fetch" : "mem");
      if (tmo) return;
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check('0, tag);
    repeat (2) @(posedge clock);
    #1;
    check('0, "reset_hold");
    reset = 1'b0;
  endtask

  // Runs a whole instruction, including refetches after an aborted access.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int d_if_in,
                           input int d_mem_in, input logic zz);
    int   idx, c, d_if, d_mem;
    logic ok;
    idx = classify(o, f);
    nx_op = o;
    nx_func = f;
    d_if = d_if_in;
    d_mem = d_mem_in;
    for (int a = 0; a < 4; a++) begin
      wait_phase(1'b1, idx, d_if, ok);
      if (!ok) begin
        d_if = 0;
        continue;
      end
      step(e_decode(idx), 1'($urandom), 1'($urandom), 1'b0, "decode");
      if (idx < 0) begin
`ifdef ILLEGAL_TRAP_EN
        for (int t = 0; t < 3; t++) begin
          ctl_t e;
          e = '0;
          e.st = 3'd5;
          step(e, 1'($urandom), 1'($urandom), 1'b0, "trap");
        end
        do_reset("reset_in_trap");
`endif
        return;
      end
      c = tbl[idx].cls;
      if (c == C_J || c == C_JAL || c == C_JR) return;
      step(e_exec(idx, zz), 1'($urandom), zz, 1'b0, "exec");
      if (c == C_BEQ || c == C_BNE) return;
      if (c == C_LW || c == C_SW) begin
        wait_phase(1'b0, idx, d_mem, ok);
        if (!ok) begin
          d_mem = 0;
          d_if = 0;
          continue;
        end
        if (c == C_SW) return;
      end
      step(e_wb(idx), 1'($urandom), 1'($urandom), 1'b0, "wb");
      return;
    end
  endtask

  initial begin
    ctl_t e;
    reset = 1'b1;
    op = '0;
    func = '0;
    z = 1'b0;
    mem_ready = 1'b0;
    nx_op = '0;
    nx_func = '0;

    // reset state
    @(negedge clock);
    #1;
    check('0, "reset_outputs");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // directed steps
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);   // add: IF ID EXE WB
    run_instr(6'b100011, 6'b000000, 0, 3, 1'b0);   // lw with three idle MEM cycles
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);   // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);   // beq not taken
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b1);   // bne not taken
    run_instr(6'b000101, 6'b000000, 0, 0, 1'b0);   // bne taken
    run_instr(6'b000011, 6'b000000, 0, 0, 1'b0);   // jal
    run_instr(6'b101011, 6'b000000, 0, 99, 1'b0);  // sw whose MEM access never answers
    run_instr(6'b000000, 6'b000011, 9, 0, 1'b0);   // sra after a fetch that times out
    run_instr(6'b000000, 6'b001000, 2, 0, 1'b0);   // jr with slow fetch
    run_instr(6'b001111, 6'b010101, 0, 0, 1'b0);   // lui
    run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);   // undefined opcode
    run_instr(6'b000000, 6'b111111, 1, 0, 1'b0);   // undefined function

    // reset in the middle of a store that is waiting on memory
    nx_op = 6'b101011;
    nx_func = 6'b000000;
    step(e_fetch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1, "fetch");
    step(e_decode(14), 1'b0, 1'b0, 1'b0, "decode");
    step(e_exec(14, 1'b0), 1'b0, 1'b0, 1'b0, "exec");
    e = e_mem(14, 1'b0);
    step(e, 1'b0, 1'b0, 1'b0, "mem_wait");
    do_reset("reset_mid_sw");

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] o, f;
      int         k, d_if, d_mem;
      if ($urandom_range(0, 9) < 8) begin
        k = $urandom_range(0, 19);
        o = tbl[k].op;
        f = (o == 6'd0) ? tbl[k].func : 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      d_if = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      d_mem = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : 0;
      run_instr(o, f, d_if, d_mem, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
